// File: rtl/ysyx_22050518_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the *W variants.
// One quotient bit per cycle; quotient and remainder are returned together under valid/ready.
module ysyx_22050518_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable until then. flush overrides both channels.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] rem_r, quo_r, div_r;
  logic            q_neg, r_neg, word_r;
  logic [CW-1:0]   cnt;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  // Operand preparation: width extension, then magnitudes for signed ops.
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, quo_init, dz_rem;
  logic            a_neg, b_neg, div_zero;
  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (is_word) begin
      a_ext = is_signed ? sext_half(dividend[HALF-1:0]) : {{HALF{1'b0}}, dividend[HALF-1:0]};
      b_ext = is_signed ? sext_half(divisor[HALF-1:0])  : {{HALF{1'b0}}, divisor[HALF-1:0]};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    // Word ops run only HALF iterations, so the dividend must start in the upper half.
    quo_init = is_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
    dz_rem   = is_word ? sext_half(dividend[HALF-1:0]) : dividend;
  end

  // One restoring step: the borrow out of the XLEN+1-bit subtract decides the quotient bit.
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] sub;
  logic            borrow, last;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fix, r_fix, q_res, r_res;
  logic            unused_bits;
  always_comb begin
    rem_sh  = {rem_r, quo_r[XLEN-1]};
    sub     = {1'b0, rem_sh} - {2'b00, div_r};
    borrow  = sub[XLEN+1];
    rem_nxt = borrow ? rem_sh[XLEN-1:0] : sub[XLEN-1:0];
    quo_nxt = {quo_r[XLEN-2:0], ~borrow};
    q_fix   = q_neg ? -quo_nxt : quo_nxt;
    r_fix   = r_neg ? -rem_nxt : rem_nxt;
    q_res   = word_r ? sext_half(q_fix[HALF-1:0]) : q_fix;
    r_res   = word_r ? sext_half(r_fix[HALF-1:0]) : r_fix;
    last    = (cnt == CW'(1));
  end
  assign unused_bits = ^{sub[XLEN], rem_sh[XLEN]};

  logic accept;
  assign accept = in_valid & in_ready & ~flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = div_zero ? DONE : CALC;
        CALC:    if (last)     state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r     <= '0;
      quo_r     <= '0;
      div_r     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      word_r    <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      rem_r  <= '0;
      quo_r  <= quo_init;
      div_r  <= b_mag;
      q_neg  <= a_neg ^ b_neg;
      r_neg  <= a_neg;
      word_r <= is_word;
      cnt    <= is_word ? CW'(HALF) : CW'(XLEN);
      if (div_zero) begin
        quotient  <= '1;
        remainder <= dz_rem;
        cnt       <= '0;
      end
    end else if (state == CALC) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt   <= cnt - CW'(1);
      if (last) begin
        quotient  <= q_res;
        remainder <= r_res;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050518_div.sv
// Bench for ysyx_22050518_div: directed vector table, multi-cycle corner sequences,
// and random ops checked against an arithmetic reference of the RV64M divide rules.
module tb_ysyx_22050518_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        is_word = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int pass_cnt = 0;
  int total_cnt = 0;

  ysyx_22050518_div #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .is_signed(is_signed), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        w;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  // Reference: RISC-V M-extension results from plain arithmetic on the extended operands.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  input logic w, output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
    logic [63:0] ea, eb;
    ea = a;
    eb = b;
    if (w) begin
      ea = s ? sext32(a) : {32'b0, a[31:0]};
      eb = s ? sext32(b) : {32'b0, b[31:0]};
    end
    if (eb == 64'd0) begin
      q = '1;
      r = ea;
      if (w) r = sext32(a);
    end else if (!s) begin
      q = ea / eb;
      r = ea % eb;
    end else if (ea == 64'h8000_0000_0000_0000 && eb == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = ea;
      r = 64'd0;
    end else begin
      q = $signed(ea) / $signed(eb);
      r = $signed(ea) % $signed(eb);
    end
    if (w) begin
      q = sext32(q);
      r = sext32(r);
    end
    lat = (eb == 64'd0) ? 0 : (w ? 32 : 64);
  endfunction

  // Latency is the number of rising edges after the accept edge until out_valid is seen.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                        output logic [63:0] q, output logic [63:0] r, output int lat,
                        output logic timeout);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; is_word = w;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    timeout = ~out_valid;
    q = quotient;
    r = remainder;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t        vecs[10];
  logic [63:0] got_q, got_r, exp_q, exp_r;
  int          got_lat, exp_lat;
  logic        tmo;

  initial begin
    vecs[0] = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 64};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[2] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                64'h8000_0000_0000_0000, 64'd0, 64};
    vecs[4] = '{64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0};
    vecs[5] = '{64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32};
    vecs[6] = '{64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 32};
    vecs[7] = '{64'h8000_0005, 64'd2, 1'b0, 1'b1, 64'h4000_0002, 64'd1, 32};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 0};
    vecs[9] = '{64'h0000_0001_8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};

    // Reset state
    #12;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].w, got_q, got_r, got_lat, tmo);
      check($sformatf("vec%0d timeout", i), {63'd0, tmo}, 64'd0);
      check($sformatf("vec%0d quotient", i), got_q, vecs[i].q);
      check($sformatf("vec%0d remainder", i), got_r, vecs[i].r);
      check($sformatf("vec%0d latency", i), 64'(got_lat), 64'(vecs[i].lat));
    end

    // Flush mid-CALC discards the op; the next op is unaffected
    begin
      int seen;
      @(negedge clk);
      dividend = 64'd1000; divisor = 64'd3; is_signed = 1'b0; is_word = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush in_ready", {63'd0, in_ready}, 64'd1);
      check("flush out_valid", {63'd0, out_valid}, 64'd0);
      seen = 0;
      repeat (70) begin
        @(posedge clk);
        #1 if (out_valid) seen++;
      end
      check("flushed op no out_valid", 64'(seen), 64'd0);
      run_op(64'd9, 64'd3, 1'b0, 1'b0, got_q, got_r, got_lat, tmo);
      check("post-flush quotient", got_q, 64'd3);
      check("post-flush remainder", got_r, 64'd0);
      check("post-flush latency", 64'(got_lat), 64'd64);
    end

    // flush with in_valid in IDLE must not accept
    @(negedge clk);
    dividend = 64'd20; divisor = 64'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush blocks accept", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;

    // Hold out_ready low in DONE: outputs stable, in_ready low
    begin
      int waited, bad;
      @(negedge clk);
      dividend = 64'd50; divisor = 64'd5; is_signed = 1'b0; is_word = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      waited = 0;
      while (!out_valid && waited < 200) begin
        @(posedge clk);
        #1 waited++;
      end
      check("hold reached DONE", {63'd0, out_valid}, 64'd1);
      bad = 0;
      repeat (5) begin
        @(posedge clk);
        #1 if (!out_valid || in_ready || quotient != 64'd10 || remainder != 64'd0) bad++;
      end
      check("hold stable cycles", 64'(bad), 64'd0);
      check("hold quotient", quotient, 64'd10);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("release out_valid", {63'd0, out_valid}, 64'd0);
      check("release in_ready", {63'd0, in_ready}, 64'd1);
    end

    // Asynchronous reset mid-CALC clears outputs without a clock edge
    @(negedge clk);
    dividend = 64'd1000; divisor = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst in_ready", {63'd0, in_ready}, 64'd1);
    check("async rst out_valid", {63'd0, out_valid}, 64'd0);
    check("async rst quotient", quotient, 64'd0);
    check("async rst remainder", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random ops against the reference
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, b;
      logic s, w;
      int sel;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 64'd0;
      else if (sel == 1) b = 64'hFFFF_FFFF_FFFF_FFFF;
      else if (sel == 2) b = 64'($urandom_range(1, 20));
      else if (sel == 3) a = 64'h8000_0000_0000_0000;
      else if (sel == 4) a = 64'($urandom_range(0, 1000));
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      ref_div(a, b, s, w, exp_q, exp_r, exp_lat);
      run_op(a, b, s, w, got_q, got_r, got_lat, tmo);
      check($sformatf("rand%0d timeout", i), {63'd0, tmo}, 64'd0);
      check($sformatf("rand%0d quotient a=%h b=%h s=%0d w=%0d", i, a, b, s, w), got_q, exp_q);
      check($sformatf("rand%0d remainder a=%h b=%h s=%0d w=%0d", i, a, b, s, w), got_r, exp_r);
      check($sformatf("rand%0d latency", i), 64'(got_lat), 64'(exp_lat));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
